sv_bus_mux_demux_fifo: RTL and testbench
========================================

// Module: sv_bus_mux_demux_fifo
//
// PURPOSE
//   Elastic byte-stream FIFO placed between the mux output stream (sto_*) and
//   the demux input stream (sti_*). It decouples the producer from the consumer
//   and absorbs bursts. Both sides use a valid/ready handshake: a beat transfers
//   on a rising clk edge when vld and rdy are both high.
//   First-word-fall-through: the head entry is always presented on sto_bus.
//
// PARAMETERS
//   DW     8   data width of the stream bus in bits
//   DEPTH  16  number of entries; must be a power of 2 and >= 2
//   AW     $clog2(DEPTH)  localparam, pointer width (not overridable)
//
// PORTS
//   clk      in   1     system clock, all logic on the rising edge
//   rst      in   1     asynchronous active-low reset (0 = reset)
//   clr      in   1     synchronous flush, active high
//   sti_vld  in   1     input stream valid
//   sti_bus  in   DW    input stream data
//   sti_rdy  out  1     input stream ready, registered
//   sto_vld  out  1     output stream valid, registered
//   sto_bus  out  DW    output stream data, the head entry
//   sto_rdy  in   1     output stream ready
//   cnt      out  AW+1  current fill level, 0..DEPTH, registered
//
// BEHAVIOUR
//   - Reset (rst=0, async assert, sync release): wr_ptr=0, rd_ptr=0, cnt=0,
//     sto_vld=0, sti_rdy=0. sto_bus is don't-care while sto_vld=0.
//   - sti_rdy rises on the first rising clk edge after rst is released.
//     Thereafter sti_rdy = (cnt_next != DEPTH), registered.
//   - Definitions:
//       push = sti_vld & sti_rdy
//       pop  = sto_vld & sto_rdy
//   - push: write sti_bus into mem[wr_ptr]; wr_ptr <= wr_ptr+1, mod DEPTH.
//   - pop: rd_ptr <= rd_ptr+1, mod DEPTH.
//   - Pointers are AW bits wide and wrap silently from DEPTH-1 to 0.
//   - cnt_next:
//       cnt+1 when push only
//       cnt-1 when pop only
//       cnt   when both or neither
//   - sto_vld is registered: sto_vld = (cnt_next != 0).
//   - Latency: a byte pushed into an empty FIFO appears on sto_vld/sto_bus on
//     the next clk edge, one cycle later.
//   - No combinational path exists from sti_vld to sto_vld, or from sto_rdy to
//     sti_rdy.
//   - Empty (cnt=0): sto_vld=0. A concurrent push makes cnt=1.
//   - Full (cnt=DEPTH): sti_rdy=0, so no push is possible. A pop makes cnt=DEPTH-1,
//     and sti_rdy=1 on the next cycle.
//   - Simultaneous push and pop at 0<cnt<DEPTH: cnt is unchanged and both
//     pointers advance.
//   - clr=1 has priority over push and pop in the same cycle:
//       pointers and cnt are set to 0
//       the beat accepted that cycle is discarded
//       sto_vld=0 next cycle, sti_rdy=1 next cycle
//   - sto_bus stays stable while sto_vld=1 and sto_rdy=0. The producer must keep
//     sti_bus and sti_vld stable until sti_rdy.
//   - rst asserted mid-transfer aborts immediately. All contents are lost and the
//     outputs take their reset values asynchronously.
//
// TESTING
//   1. Reset, then push 0x11,0x22,0x33 with sto_rdy=0
//      -> cnt=3, sto_vld=1, sto_bus=0x11.
//      Then sto_rdy=1 -> 0x11,0x22,0x33 are popped in order and cnt returns to 0.
//   2. With DEPTH=16, push 16 bytes 0x00..0x0F while sto_rdy=0
//      -> sti_rdy=0 and cnt=16.
//      A 17th beat held on sti is not accepted until one pop occurs.
//   3. Stream 40 bytes with sti_vld=1 and sto_rdy=1 continuously
//      -> one beat per cycle after the first-cycle latency, with ptr wrap.
//      Output equals input and cnt stays at 1.
//   4. Randomised sti_vld/sto_rdy (50%) for 1000 bytes
//      -> scoreboard matches, no loss or duplicate, 0 <= cnt <= 16 always.
//   5. Fill to cnt=5, then clr=1 with a concurrent push of 0xAA
//      -> next cycle cnt=0, sto_vld=0, and 0xAA never appears.
//   6. Drop rst low mid-stream at cnt=7
//      -> sto_vld=0, sti_rdy=0, cnt=0 immediately.
//      After release, sti_rdy=1 on the first edge and the FIFO is empty.

Source files
------------

// File: rtl/sv_bus_mux_demux_fifo_if.sv
// Stream bundle between the mux output (sto_*) and demux input (sti_*) sides of
// the elastic FIFO, plus the fill-level status.
interface sv_bus_mux_demux_fifo_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          sti_vld;
    logic [DW-1:0] sti_bus;
    logic          sti_rdy;
    logic          sto_vld;
    logic [DW-1:0] sto_bus;
    logic          sto_rdy;
    logic [AW:0]   cnt;

    // Environment side: produces sti beats, consumes sto beats.
    modport master (
        output sti_vld,
        output sti_bus,
        input  sti_rdy,
        input  sto_vld,
        input  sto_bus,
        output sto_rdy,
        input  cnt
    );

    // FIFO side.
    modport slave (
        input  sti_vld,
        input  sti_bus,
        output sti_rdy,
        output sto_vld,
        output sto_bus,
        input  sto_rdy,
        output cnt
    );
endinterface

// File: rtl/sv_bus_mux_demux_fifo.sv
// First-word-fall-through elastic byte FIFO with registered valid/ready/count
// and a synchronous flush that overrides any beat accepted in the same cycle.
module sv_bus_mux_demux_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    sv_bus_mux_demux_fifo_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic          sto_vld_r;
    logic          sti_rdy_r;

    logic          push_s;
    logic          pop_s;
    logic [AW:0]   cnt_next_s;

    // Handshake qualification and next fill level; only registered flags feed
    // the qualifiers, so no input reaches an output combinationally.
    always_comb begin
        push_s     = bus.sti_vld & sti_rdy_r;
        pop_s      = sto_vld_r & bus.sto_rdy;
        cnt_next_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + CNT_ONE;
            2'b01:   cnt_next_s = cnt_r - CNT_ONE;
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Pointer, count and flag registers; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            cnt_r     <= CNT_ZERO;
            sto_vld_r <= 1'b0;
            sti_rdy_r <= 1'b0;
        end else if (clr) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            cnt_r     <= CNT_ZERO;
            sto_vld_r <= 1'b0;
            sti_rdy_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            cnt_r     <= cnt_next_s;
            sto_vld_r <= (cnt_next_s != CNT_ZERO);
            sti_rdy_r <= (cnt_next_s != CNT_FULL);
        end
    end

    // Storage array is left unreset so it can map onto RAM; contents are
    // only observable once the count says they are valid.
    always_ff @(posedge clk) begin
        if (push_s && !clr) begin
            mem_r[wr_ptr_r] <= bus.sti_bus;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign bus.sti_rdy = sti_rdy_r;
    assign bus.sto_vld = sto_vld_r;
    assign bus.sto_bus = mem_r[rd_ptr_r];
    assign bus.cnt     = cnt_r;

endmodule

// File: tb/tb_sv_bus_mux_demux_fifo.sv
// Directed and randomised checks of the elastic FIFO against a queue model.
module tb_sv_bus_mux_demux_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    logic clr;

    sv_bus_mux_demux_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    sv_bus_mux_demux_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] in_log[$];
    logic [DW-1:0] out_log[$];
    logic          armed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic cycle(input logic vld, input logic [DW-1:0] d, input logic ordy,
                         input logic c, output logic pushed, output logic popped);
        logic exp_rdy;
        logic exp_vld;
        logic [DW-1:0] head;
        bus.sti_vld = vld;
        bus.sti_bus = d;
        bus.sto_rdy = ordy;
        clr         = c;
        #1;
        exp_rdy = armed && (model_q.size() < DEPTH);
        exp_vld = (model_q.size() != 0);
        check("sti_rdy", {31'd0, bus.sti_rdy}, {31'd0, exp_rdy});
        check("sto_vld", {31'd0, bus.sto_vld}, {31'd0, exp_vld});
        check("cnt", 32'(bus.cnt), 32'(model_q.size()));
        head = 8'h00;
        if (exp_vld) begin
            head = model_q[0];
            check("sto_bus", 32'(bus.sto_bus), 32'(head));
        end
        pushed = vld && exp_rdy && !c;
        popped = exp_vld && ordy && !c;
        @(posedge clk);
        if (c) begin
            model_q.delete();
        end else begin
            if (popped) begin
                void'(model_q.pop_front());
                out_log.push_back(head);
            end
            if (pushed) begin
                model_q.push_back(d);
                in_log.push_back(d);
            end
        end
        armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        logic p;
        logic q;
        for (int k = 0; k < 100 && model_q.size() != 0; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, p, q);
        end
        check("drained", 32'(model_q.size()), 32'd0);
    endtask

    initial begin
        logic p;
        logic q;
        logic [DW-1:0] cur;
        int sent;
        int bad;
        logic [DW-1:0] exp1 [3];

        rst         = 1'b0;
        clr         = 1'b0;
        armed       = 1'b0;
        bus.sti_vld = 1'b0;
        bus.sti_bus = 8'h00;
        bus.sto_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sto_vld", {31'd0, bus.sto_vld}, 32'd0);
        check("rst_sti_rdy", {31'd0, bus.sti_rdy}, 32'd0);
        check("rst_cnt", 32'(bus.cnt), 32'd0);
        rst = 1'b1;

        // Test 1: three bytes held, then drained in order.
        exp1[0] = 8'h11; exp1[1] = 8'h22; exp1[2] = 8'h33;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, p, q);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, exp1[i], 1'b0, 1'b0, p, q);
        end
        check("t1_cnt3", 32'(bus.cnt), 32'd3);
        check("t1_head", 32'(bus.sto_bus), 32'h11);
        out_log.delete();
        drain();
        check("t1_nout", 32'(out_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < out_log.size(); i++) begin
            check("t1_order", 32'(out_log[i]), 32'(exp1[i]));
        end

        // Test 2: fill to DEPTH, hold a 17th beat, release with one pop.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, p, q);
        end
        check("t2_full_cnt", 32'(bus.cnt), 32'(DEPTH));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h10, 1'b0, 1'b0, p, q);
        end
        cycle(1'b1, 8'h10, 1'b1, 1'b0, p, q);
        cycle(1'b1, 8'h10, 1'b0, 1'b0, p, q);
        check("t2_17th_taken", 32'(bus.cnt), 32'(DEPTH));
        drain();

        // Test 3: continuous streaming with pointer wrap.
        out_log.delete();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, p, q);
        end
        check("t3_cnt1", 32'(bus.cnt), 32'd1);
        drain();
        check("t3_nout", 32'(out_log.size()), 32'd40);
        bad = 0;
        for (int i = 0; i < out_log.size(); i++) begin
            if (out_log[i] !== 8'(8'h40 + i)) bad++;
        end
        check("t3_order", 32'(bad), 32'd0);

        // Test 4: random valid/ready for 1000 bytes.
        in_log.delete();
        out_log.delete();
        sent = 0;
        cur  = 8'($urandom);
        for (int k = 0; k < 20000 && (sent < 1000 || model_q.size() != 0); k++) begin
            cycle((sent < 1000) && ($urandom_range(0, 1) == 1), cur,
                  $urandom_range(0, 1) == 1, 1'b0, p, q);
            if (p) begin
                sent++;
                cur = 8'($urandom);
            end
        end
        check("t4_sent", 32'(sent), 32'd1000);
        check("t4_nout", 32'(out_log.size()), 32'd1000);
        bad = 0;
        for (int i = 0; i < out_log.size() && i < in_log.size(); i++) begin
            if (out_log[i] !== in_log[i]) bad++;
        end
        check("t4_order", 32'(bad), 32'd0);

        // Test 5: flush at cnt=5 with a concurrent push.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, p, q);
        end
        out_log.delete();
        cycle(1'b1, 8'hAA, 1'b1, 1'b1, p, q);
        check("t5_cnt", 32'(bus.cnt), 32'd0);
        check("t5_vld", {31'd0, bus.sto_vld}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, p, q);
        end
        check("t5_no_aa", 32'(out_log.size()), 32'd0);

        // Test 6: asynchronous reset mid-stream at cnt=7.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, p, q);
        end
        bus.sti_vld = 1'b1;
        bus.sto_rdy = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("t6_vld", {31'd0, bus.sto_vld}, 32'd0);
        check("t6_rdy", {31'd0, bus.sti_rdy}, 32'd0);
        check("t6_cnt", 32'(bus.cnt), 32'd0);
        model_q.delete();
        armed = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, p, q);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, p, q);
        check("t6_rdy_after", {31'd0, bus.sti_rdy}, 32'd1);
        check("t6_empty", 32'(bus.cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
